// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and IDLE/RUN/HALT control.
// Optional halt-on-16'hFFFF detection is enabled by defining FETCH_HALT_EN.
//
// state | meaning
// IDLE  | after reset; waits for en, no fetching
// RUN   | fetching one word per cycle when IF/ID is free or being consumed
// HALT  | halt word captured; PC frozen, held word drains, left only by redirect
module fetch_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_data,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [7:0]  if_pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  pc_q;
   logic [7:0]  pc_d;
   logic        if_valid_q;
   logic [15:0] if_instr_q;
   logic [7:0]  if_pc_q;
   logic        load;
   logic        halt_word;

   assign pc_d = pc_q + 8'd1;
   assign load = (state_q == S_RUN) && (!if_valid_q || id_ready) && !redirect;

`ifdef FETCH_HALT_EN
   assign halt_word = (imem_data == 16'hFFFF);
   assign halted    = (state_q == S_HALT);
`else
   assign halt_word = 1'b0;
   assign halted    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= 8'h00;
         if_valid_q <= 1'b0;
         if_instr_q <= 16'h0000;
         if_pc_q    <= 8'h00;
      end else if (state_q == S_IDLE) begin
         // redirect is ignored here; only en leaves IDLE
         if (en)
            state_q <= S_RUN;
         if (if_valid_q && id_ready)
            if_valid_q <= 1'b0;
      end else if (redirect) begin
         state_q    <= S_RUN;
         pc_q       <= redirect_pc;
         if_valid_q <= 1'b0;
      end else if (load) begin
         if_instr_q <= imem_data;
         if_pc_q    <= pc_q;
         if_valid_q <= 1'b1;
         pc_q       <= pc_d;
         if (halt_word)
            state_q <= S_HALT;
      end else if (if_valid_q && id_ready) begin
         if_valid_q <= 1'b0;
      end
   end

   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [7:0]  if_pc;
   logic        halted;

   logic [15:0] mem [256];

   int checks = 0;
   int errors = 0;

`ifdef FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   // model: mode 0 = idle, 1 = running, 2 = halted
   int          m_mode  = 0;
   int          m_pc    = 0;
   bit          m_valid = 1'b0;
   logic [15:0] m_instr = 16'h0000;
   int          m_ipc   = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .halted      (halted)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock: apply the fetch rules to the inputs present at the edge,
   // then compare every output against the model.
   task automatic step();
      int          n_mode  = m_mode;
      int          n_pc    = m_pc;
      bit          n_valid = m_valid;
      logic [15:0] n_instr = m_instr;
      int          n_ipc   = m_ipc;
      logic [15:0] word    = mem[m_pc];
      if (rst) begin
         n_mode = 0; n_pc = 0; n_valid = 0; n_instr = 16'h0000; n_ipc = 0;
      end else if (m_mode == 0) begin
         if (en) n_mode = 1;
         if (m_valid && id_ready) n_valid = 0;
      end else if (redirect) begin
         n_mode = 1; n_pc = int'(redirect_pc); n_valid = 0;
      end else if (m_mode == 1 && (!m_valid || id_ready)) begin
         n_instr = word;
         n_ipc   = m_pc;
         n_valid = 1;
         n_pc    = (m_pc + 1) % 256;
         if (HALT_EN && word == 16'hFFFF) n_mode = 2;
      end else if (m_valid && id_ready) begin
         n_valid = 0;
      end
      @(posedge clk);
      #1;
      m_mode = n_mode; m_pc = n_pc; m_valid = n_valid; m_instr = n_instr; m_ipc = n_ipc;
      check("if_valid", {15'd0, if_valid}, {15'd0, m_valid});
      check("imem_addr", {8'd0, imem_addr}, 16'(m_pc));
      check("halted", {15'd0, halted}, {15'd0, (m_mode == 2)});
      if (m_valid) begin
         check("if_instr", if_instr, m_instr);
         check("if_pc", {8'd0, if_pc}, 16'(m_ipc));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if (w == 16'hFFFF) w = 16'h1234;
         mem[i] = w;
      end
      mem[0] = 16'h1122; mem[1] = 16'h3344; mem[2] = 16'hDEAD; mem[3] = 16'hBEEF;

      rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; id_ready = 1'b0;
      step(); step();
      check("rst_valid", {15'd0, if_valid}, 16'h0000);
      check("rst_instr", if_instr, 16'h0000);
      check("rst_pc", {8'd0, if_pc}, 16'h0000);

      // straight-line fetch
      rst = 1'b0; en = 1'b1; id_ready = 1'b1;
      step();
      en = 1'b0;
      step(); check("seq_1122", if_instr, 16'h1122); check("seq_pc0", {8'd0, if_pc}, 16'h0000);
      step(); check("seq_3344", if_instr, 16'h3344); check("seq_pc1", {8'd0, if_pc}, 16'h0001);

      // stall three cycles on 3344
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_instr", if_instr, 16'h3344);
         check("stall_addr", {8'd0, imem_addr}, 16'h0002);
      end
      id_ready = 1'b1;
      step(); check("stall_rel", if_instr, 16'hDEAD);

      // redirect while stalled
      id_ready = 1'b0;
      step();
      redirect = 1'b1; redirect_pc = 8'h40;
      step(); check("redir_valid", {15'd0, if_valid}, 16'h0000); check("redir_addr", {8'd0, imem_addr}, 16'h0040);
      redirect = 1'b0; id_ready = 1'b1;
      step(); check("redir_instr", if_instr, mem[8'h40]); check("redir_pc", {8'd0, if_pc}, 16'h0040);

      // PC wrap
      redirect = 1'b1; redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      step(); check("wrap_pcff", {8'd0, if_pc}, 16'h00FF); check("wrap_addr", {8'd0, imem_addr}, 16'h0000);
      step(); check("wrap_pc00", {8'd0, if_pc}, 16'h0000);

      // halt word at address 2
      rst = 1'b1;
      step();
      rst = 1'b0; en = 1'b1; mem[2] = 16'hFFFF;
      step();
      en = 1'b0;
      step(); step(); step();
      check("halt_word", if_instr, 16'hFFFF);
      step();
      if (HALT_EN) begin
         check("halt_flag", {15'd0, halted}, 16'h0001);
         check("halt_addr", {8'd0, imem_addr}, 16'h0003);
         redirect = 1'b1; redirect_pc = 8'h00;
         step(); check("halt_exit", {15'd0, halted}, 16'h0000);
         redirect = 1'b0;
         step(); check("halt_resume", if_instr, 16'h1122);
      end else begin
         check("nohalt_next", if_instr, 16'hBEEF);
      end
      mem[2] = 16'hDEAD;

      // reset mid-stream, then idle without en
      rst = 1'b1;
      step(); check("mid_rst_valid", {15'd0, if_valid}, 16'h0000); check("mid_rst_addr", {8'd0, imem_addr}, 16'h0000);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); check("idle_hold", {8'd0, imem_addr}, 16'h0000);
      end

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom % 60) == 0;
         en          = ($urandom % 4) == 0;
         id_ready    = ($urandom % 3) != 0;
         redirect    = ($urandom % 12) == 0;
         redirect_pc = 8'($urandom);
         if (($urandom % 4) == 0)
            mem[$urandom % 256] = (($urandom % 6) == 0) ? 16'hFFFF : 16'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: rst  input  1  reset, synchronous, active-high.
REQ-003: en  input  1  start fetching; sampled only in IDLE.
REQ-004: imem_addr  output  8  fetch address to instruction memory; equals PC register (combinational from PC).
REQ-005: imem_data  input  16  instruction word returned combinationally for imem_addr in the same cycle.
REQ-006: redirect  input  1  branch/jump taken; squash and reload PC.
REQ-007: redirect_pc  input  8  target address, valid when redirect=1.
REQ-008: id_ready  input  1  decode stage accepts the current IF/ID word.
REQ-009: if_valid  output  1  IF/ID register holds a valid instruction.
REQ-010: if_instr  output  16  registered instruction.
REQ-011: if_pc  output  8  address from which if_instr was fetched.
REQ-012: halted  output  1  high while in HALT state.

Function
REQ-013: States IDLE, RUN, HALT; halted = (state==HALT).
REQ-014: IDLE -> RUN when en=1; PC and IF/ID unchanged during IDLE.
REQ-015: load = (state==RUN) && (!if_valid || id_ready) && !redirect.
REQ-016: On load: if_instr<=imem_data, if_pc<=PC, if_valid<=1, PC<=PC+1 (8-bit, 8'hFF wraps to 8'h00).
REQ-017: In RUN with if_valid=1 and id_ready=0: PC, if_instr, if_pc, if_valid held (stall).
REQ-018: In RUN with if_valid=1, id_ready=1, and no load possible: if_valid<=0 (does not occur in RUN; applies in IDLE/HALT).
REQ-019: redirect=1 in any state except IDLE: PC<=redirect_pc, if_valid<=0 next cycle, state<=RUN; overrides load, stall, and halt detection in the same cycle.
REQ-020: redirect=1 in IDLE: ignored.
REQ-021: Throughput: one instruction per cycle with id_ready=1 continuously; latency imem_addr -> if_instr one cycle.
REQ-022: First valid word after RUN entry: if_valid=1 one cycle after the RUN entry edge, if_instr=mem[0].
REQ-023: In HALT: no loads; PC frozen; if_valid clears once the held word is accepted (id_ready=1).

Reset
REQ-024: rst=1 at a clock edge: state<=IDLE, PC<=8'h00, if_valid<=0, if_instr<=16'h0000, if_pc<=8'h00; halted=0.
REQ-025: rst has priority over redirect, en, and load; reset mid-stall or mid-HALT discards the held word.

Configuration
REQ-026: Macro FETCH_HALT_EN.
REQ-027: Defined: a load with imem_data==16'hFFFF captures the word normally (if_valid=1), advances PC, and moves state RUN->HALT on the same edge.
REQ-028: Not defined: 16'hFFFF is an ordinary instruction; HALT unreachable; halted tied to 0.

Verification
REQ-029: mem={1122,3344,DEAD,BEEF}, rst then en=1, id_ready=1 -> if_instr 1122,3344,DEAD,BEEF on consecutive cycles; if_pc 0,1,2,3.
REQ-030: id_ready=0 for 3 cycles while if_instr=3344 -> if_instr/if_pc/imem_addr stable (3344/1/2); after release, DEAD next cycle.
REQ-031: redirect=1, redirect_pc=8'h40 while stalled -> next cycle if_valid=0, imem_addr=8'h40; following cycle if_instr=mem[0x40], if_pc=8'h40.
REQ-032: PC=8'hFF, id_ready=1 -> if_pc=8'hFF then 8'h00; imem_addr wraps to 8'h00.
REQ-033: FETCH_HALT_EN defined, mem[2]=FFFF -> if_instr=FFFF with if_valid=1, halted=1 next cycle, imem_addr frozen at 3; redirect to 8'h00 -> halted=0, fetch resumes at 0. Without macro -> FFFF passes, mem[3] follows.
REQ-034: rst asserted for one cycle mid-stream (and in HALT) -> if_valid=0, imem_addr=0, state IDLE; no fetch until en=1.
